// File: rtl/pixie_dp_front_end.sv
// CDP1861-style front end: line/frame timing, INT/EFx/DMA-out requests and framebuffer capture.
// CPU outputs and framebuffer writes are registered (1 clk); no backpressure, acks beyond 8 per line are dropped.
module pixie_dp_front_end #(
  parameter int MC_PER_LINE        = 14,
  parameter int LINES_PER_FRAME    = 262,
  parameter int FIRST_DISPLAY_LINE = 80,
  parameter int DISPLAY_LINES      = 128,
  parameter int INT_LINES          = 2,
  parameter int EFX_LINES          = 4,
  parameter int DMA_START_MC       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mc_tick,
  input  logic       disp_on,
  input  logic       disp_off,
  input  logic       dma_ack,
  input  logic [7:0] data_in,
  output logic       dma_out_n,
  output logic       int_n,
  output logic       efx_n,
  output logic       fb_wr_en,
  output logic [9:0] fb_addr,
  output logic [7:0] fb_data,
  output logic [8:0] line_count
);

  localparam logic [3:0] MC_LAST       = 4'(MC_PER_LINE - 1);
  localparam logic [3:0] DMA_FIRST     = 4'(DMA_START_MC);
  localparam logic [3:0] DMA_LAST      = 4'(DMA_START_MC + 7);
  localparam logic [8:0] LINE_LAST     = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] DISP_FIRST    = 9'(FIRST_DISPLAY_LINE);
  localparam logic [8:0] DISP_LAST     = 9'(FIRST_DISPLAY_LINE + DISPLAY_LINES - 1);
  localparam logic [8:0] INT_FIRST     = 9'(FIRST_DISPLAY_LINE - INT_LINES);
  localparam logic [8:0] EFX_TOP_FIRST = 9'(FIRST_DISPLAY_LINE - EFX_LINES);
  localparam logic [8:0] EFX_BOT_FIRST = 9'(FIRST_DISPLAY_LINE + DISPLAY_LINES - EFX_LINES);

  logic [3:0] mc_count;
  logic [3:0] byte_idx;
  logic       enabled;
  logic       line_enabled;
  logic       line_wrap;
  logic       display_line;
  logic       in_int;
  logic       in_efx;
  logic       in_dma;
  logic       ack_ok;
  logic [6:0] row;

  always_comb begin
    line_wrap    = mc_tick && (mc_count == MC_LAST);
    display_line = (line_count >= DISP_FIRST) && (line_count <= DISP_LAST);
    in_int       = (line_count >= INT_FIRST) && (line_count < DISP_FIRST);
    in_efx       = ((line_count >= EFX_TOP_FIRST) && (line_count < DISP_FIRST)) ||
                   ((line_count >= EFX_BOT_FIRST) && (line_count <= DISP_LAST));
    in_dma       = (mc_count >= DMA_FIRST) && (mc_count <= DMA_LAST);
    // byte_idx saturates at 8, so bit 3 alone marks a full line
    ack_ok       = dma_ack && line_enabled && display_line && !byte_idx[3];
    row          = 7'(line_count - DISP_FIRST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mc_count     <= '0;
      line_count   <= '0;
      enabled      <= 1'b0;
      line_enabled <= 1'b0;
      byte_idx     <= '0;
      dma_out_n    <= 1'b1;
      int_n        <= 1'b1;
      efx_n        <= 1'b1;
      fb_wr_en     <= 1'b0;
      fb_addr      <= '0;
      fb_data      <= '0;
    end else begin
      if (mc_tick)
        mc_count <= line_wrap ? 4'd0 : mc_count + 4'd1;
      if (line_wrap) begin
        line_count   <= (line_count == LINE_LAST) ? 9'd0 : line_count + 9'd1;
        line_enabled <= enabled;
      end

      if (disp_off)
        enabled <= 1'b0;
      else if (disp_on)
        enabled <= 1'b1;

      // a boundary ack still uses the old byte_idx above, then the line restarts
      if (line_wrap)
        byte_idx <= '0;
      else if (ack_ok)
        byte_idx <= byte_idx + 4'd1;

      dma_out_n <= !(line_enabled && display_line && in_dma);
      int_n     <= !(line_enabled && in_int);
      efx_n     <= !in_efx;

      fb_wr_en <= ack_ok;
      if (ack_ok) begin
        fb_addr <= {row, byte_idx[2:0]};
        fb_data <= data_in;
      end
    end
  end

endmodule

// File: tb/tb_pixie_dp_front_end.sv
// Randomized bench for pixie_dp_front_end: frame-arithmetic reference model, per-cycle compare,
// plus directed frame-level checks with hand-computed counts.
module tb_pixie_dp_front_end;

  localparam int MC     = 14;
  localparam int LINES  = 262;
  localparam int FTICKS = MC * LINES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mc_tick = 1'b0;
  logic       disp_on = 1'b0;
  logic       disp_off = 1'b0;
  logic       dma_ack = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       dma_out_n;
  logic       int_n;
  logic       efx_n;
  logic       fb_wr_en;
  logic [9:0] fb_addr;
  logic [7:0] fb_data;
  logic [8:0] line_count;

  always #5 clk = ~clk;

  pixie_dp_front_end dut (
    .clk        (clk),
    .reset      (reset),
    .mc_tick    (mc_tick),
    .disp_on    (disp_on),
    .disp_off   (disp_off),
    .dma_ack    (dma_ack),
    .data_in    (data_in),
    .dma_out_n  (dma_out_n),
    .int_n      (int_n),
    .efx_n      (efx_n),
    .fb_wr_en   (fb_wr_en),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .line_count (line_count)
  );

  // Reference model: position in the frame is a single tick count; line and
  // machine cycle fall out of division by the line length.
  int m_ticks = 0;
  int m_frame = 0;
  int m_bidx  = 0;
  bit m_en    = 1'b0;
  bit m_len   = 1'b0;
  bit e_dma_n = 1'b1;
  bit e_int_n = 1'b1;
  bit e_efx_n = 1'b1;
  bit e_wr    = 1'b0;
  int e_addr  = 0;
  int e_data  = 0;

  always @(posedge clk) begin
    int  mc;
    int  ln;
    bit  disp;
    bit  acc;
    if (reset) begin
      m_ticks = 0; m_frame = 0; m_bidx = 0; m_en = 1'b0; m_len = 1'b0;
      e_dma_n = 1'b1; e_int_n = 1'b1; e_efx_n = 1'b1; e_wr = 1'b0; e_addr = 0; e_data = 0;
    end else begin
      mc   = m_ticks % MC;
      ln   = m_ticks / MC;
      disp = (ln >= 80) && (ln <= 207);
      e_dma_n = !(m_len && disp && mc >= 3 && mc <= 10);
      e_int_n = !(m_len && ln >= 78 && ln <= 79);
      e_efx_n = !((ln >= 76 && ln <= 79) || (ln >= 204 && ln <= 207));
      acc  = dma_ack && m_len && disp && (m_bidx < 8);
      e_wr = acc;
      if (acc) begin
        e_addr = (ln - 80) * 8 + m_bidx;
        e_data = int'(data_in);
        m_bidx++;
      end
      if (mc_tick) begin
        if (mc == MC - 1) begin
          m_len  = m_en;
          m_bidx = 0;
        end
        m_ticks++;
        if (m_ticks == FTICKS) begin
          m_ticks = 0;
          m_frame++;
        end
      end
      if (disp_off) m_en = 1'b0;
      else if (disp_on) m_en = 1'b1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  bit dense    = 1'b1;
  bit auto_ack = 1'b0;

  int efx_line [LINES];
  int dma_line [LINES];
  int int_low = 0;
  int wr_addr_q[$];
  int wr_data_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("dma_out_n",  int'(dma_out_n),  int'(e_dma_n));
    check("int_n",      int'(int_n),      int'(e_int_n));
    check("efx_n",      int'(efx_n),      int'(e_efx_n));
    check("fb_wr_en",   int'(fb_wr_en),   int'(e_wr));
    check("fb_addr",    int'(fb_addr),    e_addr);
    check("fb_data",    int'(fb_data),    e_data);
    check("line_count", int'(line_count), m_ticks / MC);
  endtask

  task automatic observe();
    int lc;
    lc = int'(line_count);
    if (lc < LINES) begin
      if (!efx_n) efx_line[lc]++;
      if (!dma_out_n) dma_line[lc]++;
    end
    if (!int_n) int_low++;
    if (fb_wr_en) begin
      wr_addr_q.push_back(int'(fb_addr));
      wr_data_q.push_back(int'(fb_data));
    end
  endtask

  task automatic cyc(input bit tick, input bit ack, input logic [7:0] d,
                     input bit on, input bit off, input bit rst);
    reset = rst; mc_tick = tick; dma_ack = ack; data_in = d;
    disp_on = on; disp_off = off;
    @(posedge clk);
    #1;
    if (chk_en) begin
      compare();
      observe();
    end
  endtask

  task automatic step(input bit on, input bit off);
    bit         t;
    bit         a;
    logic [7:0] d;
    t = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
    a = auto_ack && !dma_out_n;
    d = a ? 8'((m_ticks / MC - 80) * 8 + m_bidx) : 8'($urandom);
    cyc(t, a, d, on, off, 1'b0);
  endtask

  task automatic wait_pre(input int frame, input int line, input int mc);
    int budget;
    budget = 20000;
    while (!(m_frame == frame && m_ticks == line * MC + mc)) begin
      step(1'b0, 1'b0);
      budget--;
      if (budget == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_timeout: frame %0d tick %0d, wanted frame %0d line %0d mc %0d",
                 m_frame, m_ticks, frame, line, mc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "bench aborted");
      end
    end
  endtask

  function automatic int sum_efx(input int a, input int b);
    int s;
    s = 0;
    for (int i = a; i <= b; i++) s += efx_line[i];
    return s;
  endfunction

  function automatic int sum_dma();
    int s;
    s = 0;
    for (int i = 0; i < LINES; i++) s += dma_line[i];
    return s;
  endfunction

  initial begin
    int         w0;
    int         i0;
    int         d0;
    int         d100;
    int         d101;
    int         nw;
    logic [7:0] d;
    logic [7:0] exp_d [8];

    for (int i = 0; i < LINES; i++) begin
      efx_line[i] = 0;
      dma_line[i] = 0;
    end

    repeat (3) cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    compare();

    // Frame 0: display disabled, every clk carries a tick
    dense = 1'b1; auto_ack = 1'b0;
    wait_pre(0, 261, 0);
    step(1'b1, 1'b0);
    wait_pre(1, 0, 0);
    check("f0_efx_top",   sum_efx(76, 80), 56);
    check("f0_efx_bot",   sum_efx(204, 208), 56);
    check("f0_efx_total", sum_efx(0, LINES - 1), 112);
    check("f0_int_low",   int_low, 0);
    check("f0_dma_low",   sum_dma(), 0);
    check("f0_writes",    wr_addr_q.size(), 0);

    // Frame 1: display on, acknowledge every DMA request
    auto_ack = 1'b1;
    w0 = wr_addr_q.size(); i0 = int_low;
    wait_pre(2, 0, 0);
    nw = wr_addr_q.size() - w0;
    check("f1_write_count", nw, 1024);
    check("f1_int_low", int_low - i0, 28);
    for (int i = 0; i < 1024 && i < nw; i++) begin
      check("f1_addr", wr_addr_q[w0 + i], i);
      check("f1_data", wr_data_q[w0 + i], i % 256);
    end

    // Frame 2: irregular ticks; line 100 gets 9 in-window acks and one late ack
    dense = 1'b0;
    wait_pre(2, 100, 3);
    auto_ack = 1'b0;
    w0 = wr_addr_q.size();
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom);
      if (i < 8) exp_d[i] = d;
      cyc(i != 0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    wait_pre(2, 101, 0);
    nw = wr_addr_q.size() - w0;
    check("l100_write_count", nw, 8);
    for (int i = 0; i < 8 && i < nw; i++) begin
      check("l100_addr", wr_addr_q[w0 + i], 160 + i);
      check("l100_data", wr_data_q[w0 + i], int'(exp_d[i]));
    end

    // Frame 3: disp_off mid-line 100 takes effect from line 101
    auto_ack = 1'b1;
    wait_pre(3, 100, 0);
    dense = 1'b1;
    w0 = wr_addr_q.size(); d100 = dma_line[100]; d101 = dma_line[101];
    wait_pre(3, 100, 5);
    step(1'b0, 1'b1);
    wait_pre(3, 102, 0);
    nw = wr_addr_q.size() - w0;
    check("off_l100_dma", dma_line[100] - d100, 8);
    check("off_l101_dma", dma_line[101] - d101, 0);
    check("off_write_count", nw, 8);
    for (int i = 0; i < 8 && i < nw; i++)
      check("off_addr", wr_addr_q[w0 + i], 160 + i);

    // Simultaneous on/off leaves the display off for the whole next frame
    wait_pre(3, 200, 0);
    step(1'b1, 1'b1);
    dense = 1'b0;
    wait_pre(4, 0, 0);
    w0 = wr_addr_q.size(); i0 = int_low; d0 = sum_dma();
    wait_pre(5, 0, 0);
    check("onoff_int_low", int_low - i0, 0);
    check("onoff_dma_low", sum_dma() - d0, 0);
    check("onoff_writes",  wr_addr_q.size() - w0, 0);

    // Reset the clk after an accepted ack on line 90
    auto_ack = 1'b0;
    step(1'b1, 1'b0);
    wait_pre(5, 90, 5);
    cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("l90_wr_en", int'(fb_wr_en), 1);
    check("l90_addr",  int'(fb_addr), 80);
    check("l90_data",  int'(fb_data), 165);
    cyc(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
    check("rst_wr_en", int'(fb_wr_en), 0);
    check("rst_addr",  int'(fb_addr), 0);
    check("rst_data",  int'(fb_data), 0);
    check("rst_line",  int'(line_count), 0);
    check("rst_dma_n", int'(dma_out_n), 1);
    check("rst_int_n", int'(int_n), 1);
    dense = 1'b1;
    repeat (40) step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixie_dp_front_end.md
Name: pixie_dp_front_end

Overview:
CDP1861-compatible Pixie front end. It sits between the 1802 CPU core and the dual-port framebuffer, upstream of the Pixie display back end. It generates the CPU-side line and frame timing: INT, EFx and the DMA-out request. It captures each DMA-out byte and writes it into the 64x128 (1024-byte) framebuffer that the back end scans out.

Parameters:
MC_PER_LINE, 14, CPU machine cycles per scan line
LINES_PER_FRAME, 262, lines per frame
FIRST_DISPLAY_LINE, 80, first line that fetches bitmap data
DISPLAY_LINES, 128, number of bitmap lines per frame
INT_LINES, 2, number of lines INT is held active, ending at FIRST_DISPLAY_LINE-1
EFX_LINES, 4, EFx active width before the first display line and before the last display line boundary
DMA_START_MC, 3, machine cycle index of the first DMA request in a display line (8 consecutive requests)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mc_tick  in  1  one-clk pulse per CPU machine cycle
disp_on  in  1  one-clk pulse: enable display (CPU INP 1)
disp_off  in  1  one-clk pulse: disable display (CPU OUT 1)
dma_ack  in  1  one-clk strobe: CPU DMA-out cycle, data_in valid
data_in  in  8  CPU data bus during dma_ack
dma_out_n  out  1  DMA-out request to CPU, active low
int_n  out  1  interrupt request to CPU, active low
efx_n  out  1  EF1 flag to CPU, active low
fb_wr_en  out  1  framebuffer write strobe
fb_addr  out  10  framebuffer address {row[6:0], byte[2:0]}
fb_data  out  8  framebuffer write data
line_count  out  9  current line number, for debug and verification

Behaviour:
- Reset (synchronous, clk edge with reset=1): every register takes its reset value next clk, including mid-DMA.
  - mc_count=0, line_count=0, enabled=0, line_enabled=0, byte_idx=0.
  - dma_out_n=1, int_n=1, efx_n=1, fb_wr_en=0, fb_addr=0, fb_data=0.
  - A write not yet issued is dropped.
- Counters advance only on mc_tick:
  - mc_count runs 0..MC_PER_LINE-1 and wraps to 0.
  - On the wrap, line_count increments, wrapping LINES_PER_FRAME-1 -> 0 (9-bit counter).
- Enable control:
  - disp_on sets enabled; disp_off clears it.
  - If both arrive in the same clk, off wins.
  - line_enabled is loaded from enabled at each line boundary (mc_tick with mc_count wrap). A mid-line change therefore affects only the next line.
- display_line = line_count in [FIRST_DISPLAY_LINE, FIRST_DISPLAY_LINE+DISPLAY_LINES-1] (80..207).
- int_n:
  - Low when line_enabled and line_count is in [FIRST_DISPLAY_LINE-INT_LINES, FIRST_DISPLAY_LINE-1] (78..79); high otherwise.
  - Not cleared by dma_ack.
- efx_n:
  - Low for line_count in 76..79 and 204..207, i.e. [FIRST-EFX_LINES, FIRST-1] and [FIRST+DISPLAY_LINES-EFX_LINES, FIRST+DISPLAY_LINES-1].
  - Independent of enable.
- dma_out_n:
  - Low when line_enabled, display_line, and mc_count is in [DMA_START_MC, DMA_START_MC+7] (3..10); high otherwise.
- All three CPU outputs are registered and update the clk after the counter change.
- byte_idx (4 bits, 0..8):
  - Cleared at each line boundary.
  - Incremented on each accepted ack; saturates at 8.
- An ack is accepted when all of the following hold: dma_ack=1, line_enabled, display_line, byte_idx<8. Acks outside the window or beyond 8 per line are ignored (no write, no counter change).
- For an accepted ack, the following clk registers:
  - fb_wr_en=1
  - fb_addr={line_count-FIRST_DISPLAY_LINE [6:0], byte_idx[2:0]}
  - fb_data=data_in
- fb_wr_en is otherwise 0; fb_addr and fb_data hold their last values. Write latency is exactly 1 clk.
- dma_ack coincident with mc_tick at a line boundary uses the pre-boundary line_count and byte_idx.

Test Plan:
1. Reset, enabled=0, run 262*14 mc_ticks.
   - efx_n low exactly on lines 76-79 and 204-207.
   - int_n and dma_out_n stay 1; no fb_wr_en.
2. disp_on, then a full frame with dma_ack on every dma_out_n cycle and data_in=addr[7:0].
   - 1024 writes, addresses 0..1023 in order with matching data.
   - int_n low for exactly 28 mc_ticks (lines 78-79).
3. Line 100: 9 acks inside the window plus 1 ack at mc_count=12.
   - Exactly 8 writes, to addresses 160..167.
4. disp_on and disp_off in the same clk.
   - Display stays off: no int_n or dma_out_n activity next frame.
5. disp_off at line 100, mc_count=5.
   - Line 100 completes all 8 DMA requests and writes; line 101 has dma_out_n=1 throughout.
6. reset asserted the clk after an accepted ack at line 90.
   - Next clk: fb_wr_en=0, fb_addr=0, line_count=0, dma_out_n=1, int_n=1.
